// File: rtl/out_pass4_ser_frame_config.sv
// Fabric-to-pad output BEL for the RAM_IO tile: four pass lanes (comb or registered
// per lane) or a 4-bit serialiser with frame marker and Busy handshake on O0/O1.
module out_pass4_ser_frame_config #(
  parameter int unsigned NoConfigBits = 6
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic                    I0,
  input  logic                    I1,
  input  logic                    I2,
  input  logic                    I3,
  input  logic                    Load,
  output logic                    O0,
  output logic                    O1,
  output logic                    O2,
  output logic                    O3,
  output logic                    Busy,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int unsigned NLanes   = 4;
  localparam int unsigned CntW     = 2;
  localparam int unsigned SerEnBit = 4;
  localparam int unsigned OrderBit = 5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  logic [NLanes-1:0] word_in;
  logic [NLanes-1:0] lane_q;
  logic [NLanes-1:0] sr_q;
  logic              sdo_q;
  logic              frame_q;
  logic              msb_first_q;
  logic [CntW-1:0]   cnt_q;
  state_t            state_q;

  logic              ser_en;
  logic              ord_cfg;
  logic              last_bit;

  assign word_in  = {I3, I2, I1, I0};
  assign ser_en   = ConfigBits[SerEnBit];
  assign ord_cfg  = ConfigBits[OrderBit];
  assign last_bit = (cnt_q == CntW'(NLanes - 1));

  // Bit idx of a word in transmit order (idx 0 goes out first).
  function automatic logic pick_bit(input logic [NLanes-1:0] word,
                                    input logic              msb_first,
                                    input logic [CntW-1:0]   idx);
    logic [CntW-1:0] pos;
    pos = msb_first ? (CntW'(NLanes - 1) - idx) : idx;
    return word[pos];
  endfunction

  // Lane registers sample every edge regardless of mode.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      lane_q <= '0;
    end else begin
      lane_q <= word_in;
    end
  end

  // Serialiser FSM; a word occupies four cycles and can be chained back-to-back.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      sdo_q       <= 1'b0;
      frame_q     <= 1'b0;
      cnt_q       <= '0;
      msb_first_q <= 1'b0;
    end else if (!ser_en) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      sdo_q   <= 1'b0;
      frame_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Load) begin
            sr_q        <= word_in;
            msb_first_q <= ord_cfg;
            sdo_q       <= pick_bit(word_in, ord_cfg, CntW'(0));
            frame_q     <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_SHIFT;
          end else begin
            sdo_q   <= 1'b0;
            frame_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            cnt_q <= cnt_q + CntW'(1);
            sdo_q <= pick_bit(sr_q, msb_first_q, cnt_q + CntW'(1));
          end else if (Load) begin
            sr_q        <= word_in;
            msb_first_q <= ord_cfg;
            sdo_q       <= pick_bit(word_in, ord_cfg, CntW'(0));
            frame_q     <= 1'b1;
            cnt_q       <= '0;
          end else begin
            sdo_q   <= 1'b0;
            frame_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Pad mapping is a pure mux on config so a mode change is seen immediately.
  always_comb begin
    O0   = ConfigBits[0] ? lane_q[0] : I0;
    O1   = ConfigBits[1] ? lane_q[1] : I1;
    O2   = ConfigBits[2] ? lane_q[2] : I2;
    O3   = ConfigBits[3] ? lane_q[3] : I3;
    Busy = 1'b0;
    if (ser_en) begin
      O0   = sdo_q;
      O1   = frame_q;
      O2   = 1'b0;
      O3   = 1'b0;
      Busy = (state_q == S_SHIFT) && !last_bit;
    end
  end

endmodule
